// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// helpers used by the receiver and the oversampling tick generator.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } uart_rx_state_t;

   // Rounded clock divider giving one tick per oversample period.
   function automatic int baud_div(input int clk, input int baud, input int os);
      int den;
      den = baud * os;
      return (clk + den / 2) / den;
   endfunction

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-cycle tick every baud_div() clocks,
// held at phase zero while clear is high so a frame starts on a known phase.
module baud_tick_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int OVERSAMPLE = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int DIV   = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = ~clear & (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes rx, oversamples with 3-sample majority
// voting at mid-bit, rejects false starts and flags bad stop bits.
module uart_rx_deserializer
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int OVERSAMPLE = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] rx_input_data,
   output logic                      rx_ready,
   output logic                      framing_error,
   output logic                      busy
);

   localparam int SC_W = $clog2(OVERSAMPLE);
   localparam int BC_W = $clog2(UART_DATA_BITS);
   localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(UART_DATA_BITS - 1);

   uart_rx_state_t            state_q, state_d;
   logic [1:0]                sync_q, sync_d;
   logic                      rxs_prev_q, rxs_prev_d;
   logic [SC_W-1:0]           sc_q, sc_d;
   logic [BC_W-1:0]           bc_q, bc_d;
   logic [1:0]                hist_q, hist_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic                      ready_q, ready_d;
   logic                      ferr_q, ferr_d;

   logic rxs;
   logic tick;
   logic tick_clear;
   logic mid_tick;
   logic vote;

   assign rxs        = sync_q[1];
   assign tick_clear = (state_q == IDLE);
   assign mid_tick   = tick & (sc_q == SC_MID);
   // Two stored samples plus the live one span the three mid-bit ticks.
   assign vote       = maj3({hist_q, rxs});

   assign rx_input_data = data_q;
   assign rx_ready      = ready_q;
   assign framing_error = ferr_q;
   assign busy          = (state_q != IDLE);

   baud_tick_gen #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .OVERSAMPLE(OVERSAMPLE)
   ) u_tick (
      .clock(clock),
      .reset(reset),
      .clear(tick_clear),
      .tick (tick)
   );

   always_comb begin
      sync_d     = {sync_q[0], rx};
      rxs_prev_d = rxs;
      state_d    = state_q;
      sc_d       = sc_q;
      bc_d       = bc_q;
      hist_d     = hist_q;
      shift_d    = shift_q;
      data_d     = data_q;
      ready_d    = 1'b0;
      ferr_d     = 1'b0;

      // sc free-runs modulo OVERSAMPLE so every later vote lands one bit apart.
      if (tick) begin
         hist_d = {hist_q[0], rxs};
         sc_d   = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (rxs_prev_q && !rxs) begin
               state_d = START;
               sc_d    = '0;
            end
         end
         START: begin
            if (mid_tick) begin
               if (vote) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  bc_d    = '0;
               end
            end
         end
         DATA: begin
            if (mid_tick) begin
               shift_d = {vote, shift_q[UART_DATA_BITS-1:1]};
               if (bc_q == BC_LAST) begin
                  state_d = STOP;
               end else begin
                  bc_d = bc_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (mid_tick) begin
               if (vote) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_IDLE;
                  sc_d    = '0;
               end
            end
         end
         WAIT_IDLE: begin
            // sc counts consecutive high ticks; any low sample restarts the bit.
            if (tick) begin
               if (!rxs) begin
                  sc_d = '0;
               end else if (sc_q == SC_LAST) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q     <= 2'b11;
         rxs_prev_q <= 1'b1;
         state_q    <= IDLE;
         sc_q       <= '0;
         bc_q       <= '0;
         hist_q     <= 2'b11;
         shift_q    <= '0;
         data_q     <= '0;
         ready_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         rxs_prev_q <= rxs_prev_d;
         state_q    <= state_d;
         sc_q       <= sc_d;
         bc_q       <= bc_d;
         hist_q     <= hist_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         ready_q    <= ready_d;
         ferr_q     <= ferr_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer, run at a faster baud so one bit
// is 256 clocks (divider exactly 16, 16x oversampling).
module tb_uart_rx_deserializer;

   localparam int BIT = 256;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] rx_input_data;
   logic       rx_ready;
   logic       framing_error;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   int          cyc       = 0;
   int          ready_cnt = 0;
   int          ferr_cnt  = 0;
   int          both_cnt  = 0;
   logic [7:0]  ready_data [32];
   int          ready_time [32];

   uart_rx_deserializer #(
      .CLK_FREQ  (100_000_000),
      .BAUD_RATE (390_625),
      .OVERSAMPLE(16)
   ) dut (
      .clock        (clk),
      .reset        (rst),
      .rx           (rx),
      .rx_input_data(rx_input_data),
      .rx_ready     (rx_ready),
      .framing_error(framing_error),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_ready) begin
         if (ready_cnt < 32) begin
            ready_data[ready_cnt] = rx_input_data;
            ready_time[ready_cnt] = cyc;
         end
         $display("rx byte 0x%02h at cycle %0d", rx_input_data, cyc);
         ready_cnt = ready_cnt + 1;
      end
      if (framing_error) begin
         $display("framing error pulse at cycle %0d", cyc);
         ferr_cnt = ferr_cnt + 1;
      end
      if (rx_ready && framing_error) both_cnt = both_cnt + 1;
   end

   // Drive one bit time starting at a falling clock edge; a non-negative
   // noise offset inverts nothing but forces a one-clock high pulse.
   task automatic drive_bit(input logic v, input int noise);
      for (int i = 0; i < BIT; i++) begin
         rx = (i == noise) ? 1'b1 : v;
         @(negedge clk);
      end
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) drive_bit(1'b1, -1);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int noise_bit);
      drive_bit(1'b0, -1);
      for (int i = 0; i < 8; i++) drive_bit(b[i], (i == noise_bit) ? BIT / 2 : -1);
      drive_bit(stop_bit, -1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (rx_input_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_data: got %h expected 00", rx_input_data);
      end
      n_checks++;
      if (rx_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 0", rx_ready);
      end
      n_checks++;
      if (framing_error !== 1'b0) begin
         n_fail++; $display("FAIL reset_ferr: got %b expected 0", framing_error);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_good_byte;
      int r0, f0;
      r0 = ready_cnt; f0 = ferr_cnt;
      send_byte(8'h55, 1'b1, -1);
      idle_bits(1);
      n_checks++;
      if (ready_cnt - r0 !== 1) begin
         n_fail++; $display("FAIL good_ready_count: got %0d expected 1", ready_cnt - r0);
      end
      n_checks++;
      if (rx_input_data !== 8'h55) begin
         n_fail++; $display("FAIL good_data: got %h expected 55", rx_input_data);
      end
      n_checks++;
      if (ferr_cnt - f0 !== 0) begin
         n_fail++; $display("FAIL good_ferr_count: got %0d expected 0", ferr_cnt - f0);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL good_busy_idle: got %b expected 0", busy);
      end
   endtask

   task automatic test_back_to_back;
      int r0;
      r0 = ready_cnt;
      send_byte(8'hA3, 1'b1, -1);
      send_byte(8'h0F, 1'b1, -1);
      idle_bits(1);
      n_checks++;
      if (ready_cnt - r0 !== 2) begin
         n_fail++; $display("FAIL b2b_ready_count: got %0d expected 2", ready_cnt - r0);
      end
      if (ready_cnt - r0 >= 2) begin
         n_checks++;
         if (ready_data[r0] !== 8'hA3) begin
            n_fail++; $display("FAIL b2b_first: got %h expected a3", ready_data[r0]);
         end
         n_checks++;
         if (ready_data[r0+1] !== 8'h0F) begin
            n_fail++; $display("FAIL b2b_second: got %h expected 0f", ready_data[r0+1]);
         end
         n_checks++;
         if (ready_time[r0+1] - ready_time[r0] !== 10 * BIT) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d",
                               ready_time[r0+1] - ready_time[r0], 10 * BIT);
         end
      end
   endtask

   task automatic test_framing;
      int r0, f0;
      r0 = ready_cnt; f0 = ferr_cnt;
      send_byte(8'hC8, 1'b0, -1);
      n_checks++;
      if (ferr_cnt - f0 !== 1) begin
         n_fail++; $display("FAIL frame_ferr_count: got %0d expected 1", ferr_cnt - f0);
      end
      n_checks++;
      if (ready_cnt - r0 !== 0) begin
         n_fail++; $display("FAIL frame_ready_count: got %0d expected 0", ready_cnt - r0);
      end
      n_checks++;
      if (rx_input_data !== 8'h0F) begin
         n_fail++; $display("FAIL frame_data_kept: got %h expected 0f", rx_input_data);
      end
      for (int i = 0; i < 3; i++) drive_bit(1'b0, -1);
      idle_bits(2);
      send_byte(8'h12, 1'b1, -1);
      idle_bits(1);
      n_checks++;
      if (ready_cnt - r0 !== 1) begin
         n_fail++; $display("FAIL break_ready_count: got %0d expected 1", ready_cnt - r0);
      end
      n_checks++;
      if (rx_input_data !== 8'h12) begin
         n_fail++; $display("FAIL break_data: got %h expected 12", rx_input_data);
      end
      n_checks++;
      if (ferr_cnt - f0 !== 1) begin
         n_fail++; $display("FAIL break_ferr_count: got %0d expected 1", ferr_cnt - f0);
      end
   endtask

   task automatic test_glitch;
      int r0, f0;
      r0 = ready_cnt; f0 = ferr_cnt;
      rx = 1'b0;
      repeat (40) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL glitch_busy_set: got %b expected 1", busy);
      end
      repeat (50) @(negedge clk);
      rx = 1'b1;
      repeat (BIT - 90) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL glitch_busy_clear: got %b expected 0", busy);
      end
      idle_bits(1);
      n_checks++;
      if (ready_cnt - r0 !== 0) begin
         n_fail++; $display("FAIL glitch_ready_count: got %0d expected 0", ready_cnt - r0);
      end
      n_checks++;
      if (ferr_cnt - f0 !== 0) begin
         n_fail++; $display("FAIL glitch_ferr_count: got %0d expected 0", ferr_cnt - f0);
      end
   endtask

   task automatic test_reset_mid_frame;
      int r0, f0;
      r0 = ready_cnt; f0 = ferr_cnt;
      drive_bit(1'b0, -1);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, -1);
      repeat (BIT / 2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (rx_input_data !== 8'h00) begin
         n_fail++; $display("FAIL midreset_data_async: got %h expected 00", rx_input_data);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL midreset_busy_async: got %b expected 0", busy);
      end
      n_checks++;
      if (rx_ready !== 1'b0 || framing_error !== 1'b0) begin
         n_fail++; $display("FAIL midreset_pulses: got %b%b expected 00", rx_ready, framing_error);
      end
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (BIT / 2 - 4) @(negedge clk);
      idle_bits(5);
      n_checks++;
      if (ready_cnt - r0 !== 0 || ferr_cnt - f0 !== 0) begin
         n_fail++; $display("FAIL midreset_no_pulse: got ready %0d ferr %0d expected 0 0",
                            ready_cnt - r0, ferr_cnt - f0);
      end
      send_byte(8'h3C, 1'b1, -1);
      idle_bits(1);
      n_checks++;
      if (ready_cnt - r0 !== 1) begin
         n_fail++; $display("FAIL after_reset_ready_count: got %0d expected 1", ready_cnt - r0);
      end
      n_checks++;
      if (rx_input_data !== 8'h3C) begin
         n_fail++; $display("FAIL after_reset_data: got %h expected 3c", rx_input_data);
      end
   endtask

   task automatic test_noise;
      int r0;
      r0 = ready_cnt;
      send_byte(8'h00, 1'b1, 2);
      idle_bits(1);
      n_checks++;
      if (ready_cnt - r0 !== 1) begin
         n_fail++; $display("FAIL noise_ready_count: got %0d expected 1", ready_cnt - r0);
      end
      n_checks++;
      if (rx_input_data !== 8'h00) begin
         n_fail++; $display("FAIL noise_data: got %h expected 00", rx_input_data);
      end
   endtask

   task automatic test_exclusive_pulses;
      n_checks++;
      if (both_cnt !== 0) begin
         n_fail++; $display("FAIL exclusive_pulses: got %0d overlapping cycles expected 0", both_cnt);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_good_byte();
      test_back_to_back();
      test_framing();
      test_glitch();
      test_reset_mid_frame();
      test_noise();
      test_exclusive_pulses();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
